// File: rtl/fifo_wptr_full.sv
// Write-side pointer/flag logic of an async FIFO (wclk domain).
// Owns the binary/Gray write pointers and produces full, almost-full, occupancy and sticky overflow.
module fifo_wptr_full #(
    parameter int ADDR_SIZE = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic                 wen,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wcount,
    output logic                 woverflow
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AF_LEVEL = (ADDR_SIZE+1)'(DEPTH - AF_MARGIN);

    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wptr;
    logic               r_wfull;
    logic               r_walmost_full;
    logic [ADDR_SIZE:0] r_wcount;
    logic               r_woverflow;

    logic               w_wen;
    logic [ADDR_SIZE:0] w_wbin_nxt;
    logic [ADDR_SIZE:0] w_wgray_nxt;
    logic [ADDR_SIZE:0] w_rbin;
    logic [ADDR_SIZE:0] w_full_match;
    logic [ADDR_SIZE:0] w_count_nxt;

    assign w_wen       = winc & ~r_wfull;
    assign w_wbin_nxt  = r_wbin + {{ADDR_SIZE{1'b0}}, w_wen};
    assign w_wgray_nxt = (w_wbin_nxt >> 1) ^ w_wbin_nxt;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it
    always_comb begin
        w_rbin = '0;
        for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign w_full_match = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
    assign w_count_nxt  = w_wbin_nxt - w_rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_nxt;
            r_wptr         <= w_wgray_nxt;
            r_wfull        <= (w_wgray_nxt == w_full_match);
            r_walmost_full <= (w_count_nxt >= AF_LEVEL);
            r_wcount       <= w_count_nxt;
            r_woverflow    <= r_woverflow | (winc & r_wfull);
        end
    end

    assign wen          = w_wen;
    assign waddr        = r_wbin[ADDR_SIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wcount       = r_wcount;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: occupancy-count model checked every cycle plus directed literal checks.
module tb_fifo_wptr_full;

    localparam int A     = 3;
    localparam int DEPTH = 1 << A;
    localparam int AFM   = 2;

    logic         wclk;
    logic         wrst_n;
    logic         winc;
    logic [A:0]   wq2_rptr;
    logic         wen;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         wfull;
    logic         walmost_full;
    logic [A:0]   wcount;
    logic         woverflow;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;

    // Model state: total accepted writes and occupancy as plain integers
    int m_wr  = 0;
    int m_occ = 0;
    bit m_full = 1'b0;
    bit m_af   = 1'b0;
    bit m_ovf  = 1'b0;

    fifo_wptr_full #(.ADDR_SIZE(A), .AF_MARGIN(AFM)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [A:0] gray(input int n);
        logic [A:0] b;
        b = n[A:0];
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_wr = 0; m_occ = 0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        end else begin
            if (winc && !m_full) m_wr++;
            else if (winc)       m_ovf = 1'b1;
            m_occ  = m_wr - rd_cnt;
            m_full = (m_occ == DEPTH);
            m_af   = (m_occ >= DEPTH - AFM);
        end
    end

    always begin
        @(posedge wclk);
        #1;
        chk("m_wen",   int'(wen),          int'(winc && !m_full));
        chk("m_waddr", int'(waddr),        m_wr % DEPTH);
        chk("m_wptr",  int'(wptr),         int'(gray(m_wr % (2*DEPTH))));
        chk("m_wfull", int'(wfull),        int'(m_full));
        chk("m_waf",   int'(walmost_full), int'(m_af));
        chk("m_wcount",int'(wcount),       m_occ);
        chk("m_wovf",  int'(woverflow),    int'(m_ovf));
    end

    task automatic tick(input bit w, input int r);
        @(negedge wclk);
        winc     = w;
        rd_cnt   = r;
        wq2_rptr = gray(r % (2*DEPTH));
        @(posedge wclk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst_n = 1'b0; winc = 1'b0; rd_cnt = 0; wq2_rptr = '0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    initial begin
        wrst_n = 1'b0; winc = 1'b0; rd_cnt = 0; wq2_rptr = '0;
        repeat (2) @(negedge wclk);
        chk("rst_wptr",   int'(wptr),   0);
        chk("rst_wcount", int'(wcount), 0);
        chk("rst_wfull",  int'(wfull),  0);
        chk("rst_waddr",  int'(waddr),  0);
        wrst_n = 1'b1;

        // 8 back-to-back writes fill the FIFO
        for (int i = 0; i < 8; i++) tick(1'b1, 0);
        chk("t1_wfull",  int'(wfull),  1);
        chk("t1_wptr",   int'(wptr),   4'b1100);
        chk("t1_wcount", int'(wcount), 8);
        chk("t1_waf",    int'(walmost_full), 1);

        // write attempt while full
        tick(1'b1, 0);
        chk("t2_wen",  int'(wen),       0);
        chk("t2_wptr", int'(wptr),      4'b1100);
        chk("t2_ovf",  int'(woverflow), 1);
        tick(1'b0, 0);
        chk("t2_ovf_sticky", int'(woverflow), 1);

        // one read frees a slot, one write refills
        tick(1'b0, 1);
        chk("t4_wfull",  int'(wfull),  0);
        chk("t4_wcount", int'(wcount), 7);
        tick(1'b1, 1);
        chk("t4_refull", int'(wfull),  1);
        chk("t4_wptr",   int'(wptr),   4'b1101);

        // reset mid-burst, between edges
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 0);
        chk("t6_pre_waddr", int'(waddr), 3);
        #1;
        wrst_n = 1'b0;
        rd_cnt = 0;
        #1;
        chk("t6_wptr",   int'(wptr),         0);
        chk("t6_waddr",  int'(waddr),        0);
        chk("t6_wcount", int'(wcount),       0);
        chk("t6_wfull",  int'(wfull),        0);
        chk("t6_waf",    int'(walmost_full), 0);
        chk("t6_ovf",    int'(woverflow),    0);
        chk("t6_wen",    int'(wen),          1);
        @(negedge wclk);
        winc = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        winc   = 1'b1;
        #1;
        chk("t6_first_waddr", int'(waddr), 0);
        chk("t6_first_wen",   int'(wen),   1);

        // almost-full threshold (first write already armed above)
        @(posedge wclk); #2;
        for (int i = 1; i < 5; i++) tick(1'b1, 0);
        chk("t3_waf5",    int'(walmost_full), 0);
        chk("t3_wcount5", int'(wcount),       5);
        tick(1'b1, 0);
        chk("t3_waf6",    int'(walmost_full), 1);
        chk("t3_wcount6", int'(wcount),       6);

        // 16 writes with the read pointer trailing by one: full Gray cycle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, i);
            chk("t5_wfull", int'(wfull), 0);
        end
        tick(1'b0, 16);
        chk("t5_wptr_wrap",  int'(wptr),   0);
        chk("t5_waddr_wrap", int'(waddr),  0);
        chk("t5_wcount",     int'(wcount), 0);

        repeat (2) @(negedge wclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
